// File: rtl/logic_gate_pipe_if.sv
// Handshake bundle for logic_gate_pipe: operand/mode input side, result output side
// and the transfer counter.
interface logic_gate_pipe_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   y;
  logic [COUNT_W-1:0] xfer_count;

  modport master (
    output in_valid, mode, a, b, out_ready,
    input  in_ready, out_valid, y, xfer_count
  );

  modport slave (
    input  in_valid, mode, a, b, out_ready,
    output in_ready, out_valid, y, xfer_count
  );
endinterface

// File: rtl/logic_gate_pipe.sv
// WIDTH-bit mode-selectable bitwise gate followed by a STAGES-deep valid/ready
// pipeline whose bubbles collapse, plus a wrapping count of output handshakes.
module logic_gate_pipe #(
  parameter int WIDTH   = 8,
  parameter int STAGES  = 2,
  parameter int COUNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_gate_pipe_if.slave bus
);

  logic [STAGES-1:0]  vld_r;
  logic [WIDTH-1:0]   data_r [STAGES];
  logic [STAGES-1:0]  free_s;
  logic [WIDTH-1:0]   op_s;
  logic [COUNT_W-1:0] cnt_r;

  // Gate result computed on the raw operands; only captured on an input handshake.
  always_comb begin
    op_s = '0;
    case (bus.mode)
      3'b000:  op_s = ~bus.a;
      3'b001:  op_s = bus.a;
      3'b010:  op_s = bus.a & bus.b;
      3'b011:  op_s = bus.a | bus.b;
      3'b100:  op_s = bus.a ^ bus.b;
      3'b101:  op_s = ~(bus.a & bus.b);
      3'b110:  op_s = ~(bus.a | bus.b);
      3'b111:  op_s = ~(bus.a ^ bus.b);
      default: op_s = '0;
    endcase
  end

  // A stage is free unless it and every stage after it are full while the output stalls.
  always_comb begin : free_calc
    logic full_v;
    full_v = 1'b1;
    free_s = '0;
    for (int k = 0; k < STAGES; k++) begin
      full_v = 1'b1;
      for (int j = k; j < STAGES; j++) begin
        full_v = full_v & vld_r[j];
      end
      free_s[k] = bus.out_ready | ~full_v;
    end
  end

  // Pipeline advance; data only moves when its source is valid, valid bits always follow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_r[k] <= '0;
      end
    end else begin
      if (free_s[0]) begin
        vld_r[0] <= bus.in_valid;
        if (bus.in_valid) begin
          data_r[0] <= op_s;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (free_s[k]) begin
          vld_r[k] <= vld_r[k-1];
          if (vld_r[k-1]) begin
            data_r[k] <= data_r[k-1];
          end
        end
      end
    end
  end

  // Completed output handshakes, wrapping silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (vld_r[STAGES-1] && bus.out_ready) begin
      cnt_r <= cnt_r + COUNT_W'(1);
    end
  end

  assign bus.in_ready   = free_s[0];
  assign bus.out_valid  = vld_r[STAGES-1];
  assign bus.y          = data_r[STAGES-1];
  assign bus.xfer_count = cnt_r;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: default instance plus a COUNT_W=2 instance
// for counter wrap.
module tb_logic_gate_pipe;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [7:0] sb_q [$];

  logic_gate_pipe_if #(.WIDTH(8), .COUNT_W(8)) if0 ();
  logic_gate_pipe_if #(.WIDTH(8), .COUNT_W(2)) if1 ();

  logic_gate_pipe #(.WIDTH(8), .STAGES(2), .COUNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  logic_gate_pipe #(.WIDTH(8), .STAGES(2), .COUNT_W(2)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gate_model(input logic [2:0] m, input logic [7:0] x,
                                            input logic [7:0] z);
    case (m)
      3'd0:    return ~x;
      3'd1:    return x;
      3'd2:    return x & z;
      3'd3:    return x | z;
      3'd4:    return x ^ z;
      3'd5:    return ~(x & z);
      3'd6:    return ~(x | z);
      3'd7:    return ~(x ^ z);
      default: return 8'h00;
    endcase
  endfunction

  // Scoreboard: outputs sampled mid-cycle, inputs pushed when a handshake is pending.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (if0.out_valid && if0.out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_out", 32'(sb_q.size()), 32'd1);
        end else begin
          check("sb_y", 32'(if0.y), 32'(sb_q.pop_front()));
        end
      end
      if (if0.in_valid && if0.in_ready) begin
        sb_q.push_back(gate_model(if0.mode, if0.a, if0.b));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    if0.in_valid = 1'b0;
    if1.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] b2b_tab [8];
    logic [1:0] exp_w;
    n_checks = 0;
    n_errors = 0;
    b2b_tab = '{8'h0F, 8'hF0, 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3};
    rst_n = 1'b0;
    if0.in_valid = 1'b0; if0.mode = 3'd0; if0.a = 8'h00; if0.b = 8'h00; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.mode = 3'd0; if1.a = 8'h00; if1.b = 8'h00; if1.out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_out_valid", 32'(if0.out_valid), 32'd0);
    check("rst_y", 32'(if0.y), 32'd0);
    check("rst_xfer", 32'(if0.xfer_count), 32'd0);
    check("rst_in_ready", 32'(if0.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single NOT transfer, latency 2
    @(posedge clk); #1;
    if0.in_valid = 1'b1; if0.mode = 3'd0; if0.a = 8'hA5; if0.out_ready = 1'b1;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    @(negedge clk);
    check("single_lat1_valid", 32'(if0.out_valid), 32'd0);
    @(negedge clk);
    check("single_lat2_valid", 32'(if0.out_valid), 32'd1);
    check("single_y", 32'(if0.y), 32'h5A);
    @(negedge clk);
    check("single_xfer", 32'(if0.xfer_count), 32'd1);
    check("single_after_valid", 32'(if0.out_valid), 32'd0);

    // Back-to-back all modes
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i < 8) begin
        if0.in_valid = 1'b1; if0.mode = 3'(i); if0.a = 8'hF0; if0.b = 8'hCC;
      end else begin
        if0.in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 8) check("b2b_in_ready", 32'(if0.in_ready), 32'd1);
      if (i >= 2) begin
        check("b2b_valid", 32'(if0.out_valid), 32'd1);
        check("b2b_y", 32'(if0.y), 32'(b2b_tab[i-2]));
      end
    end
    @(negedge clk);
    check("b2b_xfer", 32'(if0.xfer_count), 32'd8);

    // Backpressure: three inputs into a two-deep stalled pipe
    do_reset();
    @(posedge clk); #1;
    if0.out_ready = 1'b0; if0.mode = 3'd1; if0.in_valid = 1'b1; if0.a = 8'h11;
    @(negedge clk);
    check("bp_rdy0", 32'(if0.in_ready), 32'd1);
    @(posedge clk); #1;
    if0.a = 8'h22;
    @(negedge clk);
    check("bp_rdy1", 32'(if0.in_ready), 32'd1);
    @(posedge clk); #1;
    if0.a = 8'h33;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_rdy_low", 32'(if0.in_ready), 32'd0);
      check("bp_hold_valid", 32'(if0.out_valid), 32'd1);
      check("bp_hold_y", 32'(if0.y), 32'h11);
      @(posedge clk); #1;
    end
    if0.out_ready = 1'b1;
    @(negedge clk);
    check("bp_rdy_release", 32'(if0.in_ready), 32'd1);
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !if0.out_valid) break;
    end
    check("bp_drained", 32'(sb_q.size()), 32'd0);
    check("bp_xfer", 32'(if0.xfer_count), 32'd3);

    // Counter wrap on the COUNT_W=2 instance
    do_reset();
    exp_w = 2'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if1.in_valid = (i < 5); if1.mode = 3'd0; if1.a = 8'(i);
      @(negedge clk);
      check("wrap_cnt", 32'(if1.xfer_count), 32'(exp_w));
      if (if1.out_valid && if1.out_ready) exp_w = exp_w + 2'd1;
    end
    check("wrap_final", 32'(if1.xfer_count), 32'd1);

    // Mid-stream reset with two results in flight
    do_reset();
    @(posedge clk); #1;
    if0.in_valid = 1'b1; if0.mode = 3'd2; if0.a = 8'hFF; if0.b = 8'h3C; if0.out_ready = 1'b1;
    @(posedge clk); #1;
    if0.a = 8'h0F;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(if0.out_valid), 32'd0);
    check("mid_rst_y", 32'(if0.y), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_no_stale", 32'(if0.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    if0.in_valid = 1'b1; if0.mode = 3'd4; if0.a = 8'h0F; if0.b = 8'hFF;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    @(negedge clk);
    check("mid_new_lat1", 32'(if0.out_valid), 32'd0);
    @(negedge clk);
    check("mid_new_lat2", 32'(if0.out_valid), 32'd1);
    check("mid_new_y", 32'(if0.y), 32'hF0);
    @(negedge clk);
    check("mid_new_xfer", 32'(if0.xfer_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
